// File: rtl/hex_adder_scan_display.sv
// Nibble-serial WIDTH-bit adder with start/busy/done handshake and a multiplexed hex display.
// Optional build macro BLANK_LEADING_ZERO_EN blanks the leading zero digits.
module hex_seg_dec (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        if (!blank) begin
            case (nib)
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                default: seg = 7'b0001110;
            endcase
        end
    end
endmodule

module hex_adder_scan_display #(
    parameter int WIDTH    = 16,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic [6:0]         seg,
    output logic [WIDTH/4-1:0] an
);
    localparam int DIGITS = WIDTH / 4;
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [KW-1:0] KLAST = KW'(DIGITS - 1);
    localparam logic [CW-1:0] CLAST = CW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
    logic             carry;
    logic [KW-1:0]    k;
    logic [4:0]       nib_sum;

    always_comb begin
        nib_sum = {1'b0, a_r[4*k +: 4]} + {1'b0, b_r[4*k +: 4]} + {4'b0, carry};
        acc_nxt = acc;
        acc_nxt[4*k +: 4] = nib_sum[3:0];
    end

    // acc collects nibbles privately; sum is only loaded on the final stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        k     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                default: begin
                    acc   <= acc_nxt;
                    carry <= nib_sum[4];
                    k     <= k + 1'b1;
                    if (k == KLAST) begin
                        sum   <= acc_nxt;
                        cout  <= nib_sum[4];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    logic [CW-1:0] scnt;
    logic [KW-1:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
            idx  <= '0;
        end else if (scnt == CLAST) begin
            scnt <= '0;
            idx  <= (idx == KLAST) ? '0 : idx + 1'b1;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    always_comb begin
        an      = '1;
        an[idx] = 1'b0;
    end

    logic [DIGITS-1:0][6:0] dseg;
    logic [DIGITS-1:0]      blank;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
`ifdef BLANK_LEADING_ZERO_EN
        // digit 0 always shows, so a zero result still displays "0"
        if (g == 0) begin : g_lsd
            assign blank[g] = 1'b0;
        end else begin : g_hi
            assign blank[g] = ~|sum[WIDTH-1:4*g];
        end
`else
        assign blank[g] = 1'b0;
`endif
        hex_seg_dec u_dec (
            .nib   (sum[4*g +: 4]),
            .blank (blank[g]),
            .seg   (dseg[g])
        );
    end

    assign seg = dseg[idx];
endmodule

// File: tb/tb_hex_adder_scan_display.sv
// Directed bench for hex_adder_scan_display at WIDTH=16, SCAN_DIV=4.
module tb_hex_adder_scan_display;
    localparam int WIDTH    = 16;
    localparam int SCAN_DIV = 4;
`ifdef BLANK_LEADING_ZERO_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b1000000;
`endif

    logic              clk = 1'b0;
    logic              rst, start, cin;
    logic [WIDTH-1:0]  a, b;
    logic              busy, done, cout;
    logic [WIDTH-1:0]  sum;
    logic [6:0]        seg;
    logic [3:0]        an;

    int checks = 0;
    int errors = 0;
    logic [15:0] prev_sum = 16'h0000;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic [15:0] es;
        logic        ec;
    } vec_t;
    vec_t vecs[8];

    hex_adder_scan_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at a negedge; drives start there, ends at the negedge where done is high
    task automatic run_add(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                           input logic [15:0] es, input logic ec, input bit pulse_mid);
        a = va; b = vb; cin = vc; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("busy", busy, 1);
            chk("done_low", done, 0);
            chk("sum_hold", sum, prev_sum);
            if (pulse_mid && i == 0) begin
                a = 16'h9999; b = 16'h1111; cin = 1'b1; start = 1'b1;
            end
        end
        @(negedge clk);
        chk("done", done, 1);
        chk("busy_clr", busy, 0);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        prev_sum = es;
    endtask

    task automatic scan_check(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] e[4];
        logic [3:0] prev;
        logic [3:0] ea;
        bit found;
        e = '{e0, e1, e2, e3};
        found = 0;
        prev = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && an == 4'b1110) found = 1;
            else prev = an;
        end
        chk("scan_sync", found, 1);
        if (found) begin
            for (int j = 0; j < 16; j++) begin
                ea = ~(4'b0001 << (j / 4));
                chk("scan_an", an, ea);
                chk("scan_seg", seg, e[j / 4]);
                @(negedge clk);
            end
            chk("scan_wrap", an, 4'b1110);
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{16'h0123, 16'h0FFF, 1'b1, 16'h1123, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{16'h0A00, 16'h003F, 1'b0, 16'h0A3F, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'b1000000);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back: each new start is driven in the done cycle of the previous one
        for (int v = 0; v < 8; v++)
            run_add(vecs[v].va, vecs[v].vb, vecs[v].vc, vecs[v].es, vecs[v].ec, 1'b0);

        scan_check(7'b0001110, 7'b0110000, 7'b0001000, LZ);

        // start pulsed while busy must not disturb the running addition
        run_add(16'h0005, 16'h0005, 1'b0, 16'h000A, 1'b0, 1'b1);
        @(negedge clk);
        chk("no_restart", busy, 0);
        scan_check(7'b0001000, LZ, LZ, LZ);

        // async reset during the second ADD cycle
        a = 16'h1234; b = 16'h0001; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 16'h0000);
        chk("abort_cout", cout, 0);
        chk("abort_an", an, 4'b1110);
        chk("abort_seg", seg, 7'b1000000);
        @(negedge clk);
        rst = 1'b0;
        prev_sum = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_sum_hold", sum, 16'h0000);
        end
        scan_check(7'b1000000, LZ, LZ, LZ);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
